// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial frame receiver.
// Optional build macro: SERIAL_RX_PARITY_EN (PARITY state becomes reachable).
package serial_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DATA   = 2'b01,
    PARITY = 2'b10,
    STOP   = 2'b11
  } rx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/rx_sipo_reg.sv
// Serial-in / parallel-out register: shifts right, serial input enters at the MSB.
module rx_sipo_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  // Shift one bit in from the top on each enabled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_rx_shift.sv
// Serial-to-parallel frame receiver: start(0), WIDTH data bits LSB-first,
// [even parity], stop(1). Bits sampled only on tick. Word delivered via dvalid/dready.
// Optional build macro: SERIAL_RX_PARITY_EN adds the parity bit and parity_err output.
module serial_rx_shift
  import serial_rx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             sdi,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  input  logic             dready,
  output logic             frame_err,
`ifdef SERIAL_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  rx_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg;
  logic             shift_en;
  logic             word_done;
  logic             frame_bad;
  logic             hs;
`ifdef SERIAL_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             parity_bad;
`endif

  rx_sipo_reg #(.WIDTH(WIDTH)) u_sipo (
    .clk   (clk),
    .reset (reset),
    .en    (shift_en),
    .sin   (sdi),
    .q     (shreg)
  );

  assign hs = dvalid & dready;

  // State, bit counter and latched parity verdict.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
`ifdef SERIAL_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
`ifdef SERIAL_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Next-state logic; every transition is gated by tick.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_en   = 1'b0;
    word_done  = 1'b0;
    frame_bad  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    parity_bad = 1'b0;
`endif
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (sdi == START_BIT) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
`ifdef SERIAL_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          par_bad_d = (sdi != (^shreg));
          state_d   = STOP;
        end
`endif
        STOP: begin
          state_d = IDLE;
          if (sdi != STOP_BIT) begin
            frame_bad = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
          end else if (par_bad_q) begin
            parity_bad = 1'b1;
`endif
          end else begin
            word_done = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output word, handshake and error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dvalid     <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= frame_bad;
`ifdef SERIAL_RX_PARITY_EN
      parity_err <= parity_bad;
`endif
      if (word_done) begin
        // A word landing on a handshake cycle replaces the accepted one.
        if (dvalid && !dready) begin
          overrun <= 1'b1;
        end else begin
          dout   <= shreg;
          dvalid <= 1'b1;
          if (hs) overrun <= 1'b0;
        end
      end else if (hs) begin
        dvalid  <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_shift.sv
// Self-checking bench for serial_rx_shift (WIDTH=4), directed plus randomized frames.
module tb_serial_rx_shift;

  localparam int W = 4;
`ifdef SERIAL_RX_PARITY_EN
  localparam int FRAME_BITS = W + 2;
`else
  localparam int FRAME_BITS = W + 1;
`endif

  logic         clk = 1'b0;
  logic         reset, tick, sdi, dready;
  logic [W-1:0] dout;
  logic         dvalid, frame_err, overrun;
`ifdef SERIAL_RX_PARITY_EN
  logic         parity_err;
`else
  logic         parity_err;
  assign parity_err = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  serial_rx_shift #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .sdi       (sdi),
    .dout      (dout),
    .dvalid    (dvalid),
    .dready    (dready),
    .frame_err (frame_err),
`ifdef SERIAL_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Reference model: collects the bits after a start bit, judges the frame once complete.
  logic [W-1:0] m_dout;
  logic         m_dvalid, m_ferr, m_perr, m_ovr;
  bit           m_active;
  bit           m_bits[$];
  bit           m_done;
  logic [W-1:0] m_word;
  int           m_ones;

  always @(posedge clk) begin
    if (reset) begin
      m_dout = '0; m_dvalid = 0; m_ferr = 0; m_perr = 0; m_ovr = 0;
      m_active = 0; m_bits.delete();
    end else begin
      m_done = 0;
      m_ferr = 0;
      m_perr = 0;
      if (tick) begin
        if (!m_active) begin
          if (sdi == 1'b0) begin
            m_active = 1;
            m_bits.delete();
          end
        end else begin
          m_bits.push_back(sdi);
          if (m_bits.size() == FRAME_BITS) begin
            m_active = 0;
            m_word = '0;
            m_ones = 0;
            for (int i = 0; i < W; i++) begin
              m_word = m_word + (W'(m_bits[i]) << i);
              m_ones = m_ones + int'(m_bits[i]);
            end
            if (m_bits[FRAME_BITS-1] == 1'b0) m_ferr = 1;
`ifdef SERIAL_RX_PARITY_EN
            else if (((m_ones + int'(m_bits[W])) % 2) != 0) m_perr = 1;
`endif
            else m_done = 1;
          end
        end
      end
      if (m_done) begin
        if (m_dvalid && !dready) m_ovr = 1;
        else begin
          if (m_dvalid) m_ovr = 0;
          m_dout = m_word;
          m_dvalid = 1;
        end
      end else if (m_dvalid && dready) begin
        m_dvalid = 0;
        m_ovr = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({dout, dvalid, frame_err, overrun, parity_err} !==
          {m_dout, m_dvalid, m_ferr, m_ovr, m_perr}) begin
        errors++;
        $display("FAIL model_cmp t=%0t actual dout=%0h dv=%0b fe=%0b ov=%0b pe=%0b required dout=%0h dv=%0b fe=%0b ov=%0b pe=%0b",
                 $time, dout, dvalid, frame_err, overrun, parity_err,
                 m_dout, m_dvalid, m_ferr, m_ovr, m_perr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic t, input logic s, input logic r);
    tick = t; sdi = s; dready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic stop, input logic pflip,
                            input logic rdy_last, input bit rnd);
    logic b[$];
    logic r;
    b.push_back(1'b0);
    for (int i = 0; i < W; i++) b.push_back(d[i]);
`ifdef SERIAL_RX_PARITY_EN
    b.push_back((^d) ^ pflip);
`else
    if (pflip) b.push_back(1'b1); // flip has no meaning without a parity bit
    if (pflip) void'(b.pop_back());
`endif
    b.push_back(stop);
    for (int k = 0; k < b.size(); k++) begin
      if (rnd) begin
        repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom % 2), 1'($urandom % 2));
        r = 1'($urandom % 2);
      end else begin
        r = (k == b.size() - 1) ? rdy_last : 1'b0;
      end
      step(1'b1, b[k], r);
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; sdi = 1'b1; dready = 1'b0;
    @(posedge clk); #1;
    step(0, 1, 0);
    chk_en = 1;
    chk("reset_outputs", {28'd0, dout, dvalid, frame_err, overrun, parity_err}, 32'd0);
    reset = 1'b0;

    // Good frame 0xA: sdi 0,0,1,0,1,1
    send_frame(4'hA, 1, 0, 0, 0);
    chk("goodA_dout", 32'(dout), 32'hA);
    chk("goodA_dvalid", 32'(dvalid), 32'd1);
    chk("model_goodA", 32'(m_dout), 32'hA);
    repeat (3) step(0, 1, 0);
    chk("goodA_hold", {27'd0, dvalid, dout}, {27'd0, 1'b1, 4'hA});
    step(0, 1, 1);
    chk("goodA_accept", 32'(dvalid), 32'd0);

    // Framing error: 0,1,1,1,1,0
    send_frame(4'hF, 0, 0, 0, 0);
    chk("ferr_pulse", 32'(frame_err), 32'd1);
    chk("ferr_dvalid", 32'(dvalid), 32'd0);
    chk("model_ferr", 32'(m_ferr), 32'd1);
    step(0, 1, 0);
    chk("ferr_one_cycle", 32'(frame_err), 32'd0);
    send_frame(4'h5, 1, 0, 0, 0);
    chk("after_ferr_dout", {27'd0, dvalid, dout}, {27'd0, 1'b1, 4'h5});
    step(0, 1, 1);

    // Overrun
    send_frame(4'h3, 1, 0, 0, 0);
    send_frame(4'hC, 1, 0, 0, 0);
    chk("ovr_dout", 32'(dout), 32'h3);
    chk("ovr_flag", {30'd0, dvalid, overrun}, 32'd3);
    step(0, 1, 1);
    chk("ovr_clear", {30'd0, dvalid, overrun}, 32'd0);

    // Completion on a handshake cycle
    send_frame(4'h1, 1, 0, 0, 0);
    send_frame(4'h9, 1, 0, 1, 0);
    chk("simul_hs", {26'd0, dout, dvalid, overrun}, {26'd0, 4'h9, 1'b1, 1'b0});
    step(0, 1, 1);

    // Reset mid-frame
    step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
    reset = 1'b1;
    step(0, 1, 0);
    chk("midreset", {28'd0, dout, dvalid, frame_err, overrun, parity_err}, 32'd0);
    reset = 1'b0;
    send_frame(4'hF, 1, 0, 0, 0);
    chk("after_reset_F", {27'd0, dvalid, dout}, {27'd0, 1'b1, 4'hF});
    step(0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0);
      chk("idle_line", {30'd0, dvalid, frame_err}, 32'd0);
    end

`ifdef SERIAL_RX_PARITY_EN
    send_frame(4'h3, 1, 1, 0, 0);
    chk("par_err_pulse", {30'd0, parity_err, dvalid}, 32'd2);
    step(0, 1, 0);
    chk("par_err_one_cycle", 32'(parity_err), 32'd0);
    send_frame(4'h3, 1, 0, 0, 0);
    chk("par_good", {27'd0, dvalid, dout}, {27'd0, 1'b1, 4'h3});
    step(0, 1, 1);
`endif

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        repeat ($urandom_range(1, 8)) step(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
        repeat (W + 4) step(1, 1, 1'($urandom % 2));
      end else if (sel == 1) begin
        reset = 1'b1;
        step(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
        reset = 1'b0;
      end else begin
        send_frame(W'($urandom), 1'(($urandom % 8) != 0), 1'(($urandom % 8) == 0), 1'b0, 1);
      end
    end
    step(0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
